mjb_auto_player: RTL and testbench
==================================

Name: mjb_auto_player

Overview:
- Automated opponent that drives one player's three active-low throw buttons (R_n, S_n, P_n) into the MukJjiBba game, in place of a human.
- Per request it picks a pseudo-random throw (Rock/Scissor/Paper) from an 8-bit LFSR.
- It presses exactly one button for a fixed hold time, then releases for a gap before accepting the next request.
- Sits between the board top level and the game's player-2 button inputs; the game's armed indicator feeds `enable`.

Parameters:
- HOLD_CYCLES, 4, cycles the selected button is held low (legal range 1..255).
- GAP_CYCLES, 2, cycles all buttons are held high after release before done (legal range 1..255).
- LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be nonzero.

Ports:
- ck  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  game armed; low aborts any throw in progress.
- start  input  1  request one throw; sampled only in IDLE.
- R_n  output  1  Rock button, active-low, registered.
- S_n  output  1  Scissor button, active-low, registered.
- P_n  output  1  Paper button, active-low, registered.
- gbb_out  output  2  code of current/last throw: 00 none, 01 Rock, 10 Scissor, 11 Paper.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a throw completes normally.
- throw_count  output  8  completed throws, wraps 255->0.

Behaviour:
- Reset (reset=1 at a rising edge):
  - state=IDLE, R_n=S_n=P_n=1, gbb_out=00, busy=0, done=0, throw_count=0.
  - lfsr=LFSR_SEED; hold and gap counters = 0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shift left; new bit0 = b7^b5^b4^b3.
  - Steps exactly once per cycle spent in PICK, and never otherwise.
- States and transitions:
  - IDLE: start=1 and enable=1 -> PICK. start=0 or enable=0 -> stay in IDLE.
  - PICK: candidate = lfsr[1:0].
    - Candidate 00 -> stay in PICK, with the LFSR stepped.
    - Candidate nonzero -> latch gbb_out=candidate, load hold counter = HOLD_CYCLES-1, step LFSR, go to PRESS.
  - PRESS: the button matching gbb_out is 0, the other two are 1.
    - Hold counter > 0 -> decrement.
    - Hold counter = 0 -> load gap counter = GAP_CYCLES-1 and go to RELEASE.
    - Net effect: the button is low for exactly HOLD_CYCLES cycles.
  - RELEASE: all buttons 1.
    - Gap counter > 0 -> decrement.
    - Gap counter = 0 -> go to IDLE, assert done for one cycle, throw_count+1.
    - Net effect: RELEASE lasts GAP_CYCLES cycles.
- Latency:
  - start is sampled at edge k; PICK occupies cycle k+1 (first try).
  - Button is low during cycles k+2 .. k+1+HOLD_CYCLES.
  - done=1 in the first IDLE cycle after RELEASE.
- gbb_out holds the last throw in IDLE. It clears to 00 only on reset or abort.
- Mutual exclusion: at most one of R_n/S_n/P_n is 0 in any cycle, in all states including transitions.
- Abort: enable=0 in PICK, PRESS or RELEASE causes the following on the next edge:
  - go to IDLE, all buttons 1, gbb_out=00;
  - no done pulse, throw_count unchanged;
  - LFSR keeps its current value.
- Request handling:
  - start while busy=1 is ignored; it is not queued.
  - start held high continuously gives back-to-back throws; IDLE lasts exactly one cycle (the done cycle) between throws.
- Reset mid-throw: same as the reset values above. Buttons release on that edge and the LFSR reloads the seed.

Optional Feature:
- Macro: MJB_FORCE_THROW_EN.
- Defined:
  - adds input `force_gbb` [1:0];
  - in PICK, a nonzero force_gbb is latched instead of the LFSR candidate and PICK exits in one cycle;
  - the LFSR still steps once;
  - force_gbb=00 gives normal random behaviour.
- Undefined: the port does not exist and throws are always LFSR-chosen.

Test Plan:
- Reset, then start=1 for one cycle with enable=1 and default parameters:
  - first throw is Rock (seed A5, lfsr[1:0]=01);
  - R_n=0 for exactly 4 cycles starting 2 cycles after start, S_n=P_n=1 throughout;
  - 2 gap cycles, then done=1 for one cycle; throw_count=1 and gbb_out=01.
- Second start after the first throw:
  - LFSR=4A, so the throw is Scissor: S_n low 4 cycles, gbb_out=10, throw_count=2.
- start held high for 10 throws:
  - each throw is separated by exactly one IDLE cycle;
  - at most one button is low in every cycle (asserted continuously);
  - throw_count=10 and gbb_out never 00 during PRESS.
- enable dropped in the 2nd PRESS cycle:
  - next edge has all buttons 1, gbb_out=00, busy=0;
  - no done pulse, throw_count unchanged.
- Pulse start during PRESS and again during RELEASE:
  - both are ignored, with a single done pulse and throw_count incremented by 1.
- Reset asserted mid-PRESS:
  - buttons release on that edge and throw_count=0;
  - the next throw is Rock again (seed reloaded).
- With MJB_FORCE_THROW_EN defined, force_gbb=11:
  - P_n low for 4 cycles and gbb_out=11;
  - with force_gbb=00 the LFSR sequence resumes from its advanced value.

Source files
------------

// File: rtl/mjb_auto_player.sv
// mjb_auto_player: automated MukJjiBba opponent pressing one of three active-low throw buttons.
// Optional macro MJB_FORCE_THROW_EN adds force_gbb to override the pseudo-random pick.
module mjb_auto_player #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
`ifdef MJB_FORCE_THROW_EN
  input  logic [1:0] force_gbb,
`endif
  output logic       R_n,
  output logic       S_n,
  output logic       P_n,
  output logic [1:0] gbb_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] throw_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PICK    = 2'd1,
    PRESS   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Button levels ordered {R_n, S_n, P_n} for a throw code
  function automatic logic [2:0] buttons_for(input logic [1:0] code);
    logic [2:0] b;
    case (code)
      2'b01:   b = 3'b011;
      2'b10:   b = 3'b101;
      2'b11:   b = 3'b110;
      default: b = 3'b111;
    endcase
    return b;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] lfsr_r, lfsr_s;
  logic [7:0] hold_r, hold_s;
  logic [7:0] gap_r, gap_s;
  logic [1:0] gbb_s;
  logic [1:0] cand_s;
  logic [7:0] count_s;
  logic       done_s;
  logic [2:0] btn_s;

  // Next-state, counter, LFSR and registered-output values
  always_comb begin
    state_s = state_r;
    lfsr_s  = lfsr_r;
    hold_s  = hold_r;
    gap_s   = gap_r;
    gbb_s   = gbb_out;
    count_s = throw_count;
    done_s  = 1'b0;
    btn_s   = 3'b111;
`ifdef MJB_FORCE_THROW_EN
    if (force_gbb != 2'b00) begin
      cand_s = force_gbb;
    end else begin
      cand_s = lfsr_r[1:0];
    end
`else
    cand_s = lfsr_r[1:0];
`endif

    case (state_r)
      IDLE: begin
        if (start && enable) begin
          state_s = PICK;
        end else begin
          state_s = IDLE;
        end
      end
      PICK: begin
        if (!enable) begin
          state_s = IDLE;
          gbb_s   = 2'b00;
        end else begin
          lfsr_s = lfsr_step(lfsr_r);
          if (cand_s != 2'b00) begin
            gbb_s   = cand_s;
            hold_s  = HOLD_LOAD;
            state_s = PRESS;
          end else begin
            state_s = PICK;
          end
        end
      end
      PRESS: begin
        if (!enable) begin
          state_s = IDLE;
          gbb_s   = 2'b00;
        end else if (hold_r != 8'd0) begin
          hold_s = hold_r - 8'd1;
        end else begin
          gap_s   = GAP_LOAD;
          state_s = RELEASE;
        end
      end
      RELEASE: begin
        if (!enable) begin
          state_s = IDLE;
          gbb_s   = 2'b00;
        end else if (gap_r != 8'd0) begin
          gap_s = gap_r - 8'd1;
        end else begin
          state_s = IDLE;
          done_s  = 1'b1;
          count_s = throw_count + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        gbb_s   = 2'b00;
      end
    endcase

    // Buttons follow the upcoming state so they are registered without extra latency
    if (state_s == PRESS) begin
      btn_s = buttons_for(gbb_s);
    end else begin
      btn_s = 3'b111;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge ck) begin
    if (reset) begin
      state_r         <= IDLE;
      lfsr_r          <= LFSR_SEED;
      hold_r          <= 8'd0;
      gap_r           <= 8'd0;
      gbb_out         <= 2'b00;
      throw_count     <= 8'd0;
      done            <= 1'b0;
      busy            <= 1'b0;
      {R_n, S_n, P_n} <= 3'b111;
    end else begin
      state_r         <= state_s;
      lfsr_r          <= lfsr_s;
      hold_r          <= hold_s;
      gap_r           <= gap_s;
      gbb_out         <= gbb_s;
      throw_count     <= count_s;
      done            <= done_s;
      busy            <= (state_s != IDLE);
      {R_n, S_n, P_n} <= btn_s;
    end
  end

endmodule

// File: tb/tb_mjb_auto_player.sv
// Self-checking bench for mjb_auto_player: directed scenarios plus randomized throws
// compared against a throw-level reference model.
module tb_mjb_auto_player;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       ck = 1'b0;
  logic       reset;
  logic       enable;
  logic       start;
`ifdef MJB_FORCE_THROW_EN
  logic [1:0] force_gbb;
`endif
  logic       R_n, S_n, P_n;
  logic [1:0] gbb_out;
  logic       busy;
  logic       done;
  logic [7:0] throw_count;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Reference model state
  logic [7:0] m_lfsr;
  logic [1:0] m_gbb;
  logic [7:0] m_count;
  logic [1:0] m_force;

  mjb_auto_player #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .ck         (ck),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
`ifdef MJB_FORCE_THROW_EN
    .force_gbb  (force_gbb),
`endif
    .R_n        (R_n),
    .S_n        (S_n),
    .P_n        (P_n),
    .gbb_out    (gbb_out),
    .busy       (busy),
    .done       (done),
    .throw_count(throw_count)
  );

  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  // Feedback taps b7,b5,b4,b3 as a mask, new bit enters at the bottom
  function automatic logic [7:0] model_step(input logic [7:0] v);
    return 8'((v << 1) | {7'd0, ^(v & 8'hB8)});
  endfunction

  function automatic logic [2:0] pressed_pattern(input logic [1:0] code);
    logic [2:0] p;
    p = 3'b111;
    if (code == 2'b01) p = 3'b011;
    if (code == 2'b10) p = 3'b101;
    if (code == 2'b11) p = 3'b110;
    return p;
  endfunction

  // At most one button low, sampled away from the active edge
  always @(negedge ck) begin
    if (started) chk("onehot", (int'(!R_n) + int'(!S_n) + int'(!P_n)) <= 1, 1);
  end

  task automatic idle_tick;
    tick;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_btn", {R_n, S_n, P_n}, 3'b111);
    chk("idle_gbb", gbb_out, m_gbb);
    chk("idle_count", throw_count, m_count);
  endtask

  // Caller has raised start before the sampling edge. abort_at selects the PRESS cycle
  // (1..HOLD) in which enable drops or reset rises; 0 runs the throw to completion.
  task automatic run_throw(input int abort_at, input bit by_reset, input bit keep_start,
                           input bit poke_busy);
    int n;
    logic [1:0] cand;
    n = 0;
    if (m_force != 2'b00) begin
      cand   = m_force;
      m_lfsr = model_step(m_lfsr);
      n      = 1;
    end else begin
      do begin
        cand   = m_lfsr[1:0];
        m_lfsr = model_step(m_lfsr);
        n++;
      end while (cand == 2'b00);
    end

    tick;
    if (!keep_start) start = 1'b0;
    for (int t = 0; t < n; t++) begin
      chk("pick_busy", busy, 1'b1);
      chk("pick_btn", {R_n, S_n, P_n}, 3'b111);
      chk("pick_gbb", gbb_out, m_gbb);
      chk("pick_done", done, 1'b0);
      tick;
    end
    m_gbb = cand;
    for (int h = 1; h <= HOLD; h++) begin
      chk("press_btn", {R_n, S_n, P_n}, pressed_pattern(cand));
      chk("press_gbb", gbb_out, cand);
      chk("press_busy", busy, 1'b1);
      if (poke_busy) start = (h == 1);
      if (abort_at == h) begin
        if (by_reset) begin
          reset = 1'b1;
          tick;
          reset   = 1'b0;
          m_lfsr  = 8'hA5;
          m_count = 8'd0;
        end else begin
          enable = 1'b0;
          tick;
          enable = 1'b1;
        end
        m_gbb = 2'b00;
        chk("abort_btn", {R_n, S_n, P_n}, 3'b111);
        chk("abort_gbb", gbb_out, 2'b00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_count", throw_count, m_count);
        return;
      end
      tick;
    end
    for (int g = 1; g <= GAP; g++) begin
      chk("gap_btn", {R_n, S_n, P_n}, 3'b111);
      chk("gap_busy", busy, 1'b1);
      chk("gap_done", done, 1'b0);
      chk("gap_gbb", gbb_out, cand);
      if (poke_busy) start = (g == 1);
      tick;
    end
    if (poke_busy) start = 1'b0;
    m_count = m_count + 8'd1;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_btn", {R_n, S_n, P_n}, 3'b111);
    chk("done_gbb", gbb_out, cand);
    chk("done_count", throw_count, m_count);
  endtask

  initial begin
    int kind;
    reset   = 1'b1;
    enable  = 1'b1;
    start   = 1'b0;
    m_force = 2'b00;
`ifdef MJB_FORCE_THROW_EN
    force_gbb = 2'b00;
`endif
    tick;
    tick;
    started = 1'b1;
    chk("rst_btn", {R_n, S_n, P_n}, 3'b111);
    chk("rst_gbb", gbb_out, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_count", throw_count, 8'd0);
    reset   = 1'b0;
    m_lfsr  = 8'hA5;
    m_gbb   = 2'b00;
    m_count = 8'd0;
    idle_tick;

    // First throw from seed A5 is Rock, second from 4A is Scissor
    start = 1'b1;
    run_throw(0, 1'b0, 1'b0, 1'b0);
    chk("first_rock", gbb_out, 2'b01);
    idle_tick;
    start = 1'b1;
    run_throw(0, 1'b0, 1'b0, 1'b0);
    chk("second_scissor", gbb_out, 2'b10);
    chk("second_count", throw_count, 8'd2);
    idle_tick;

    // Ten back-to-back throws with start held
    start = 1'b1;
    for (int i = 0; i < 10; i++) run_throw(0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    chk("b2b_count", throw_count, 8'd12);
    idle_tick;

    // enable dropped in second PRESS cycle
    start = 1'b1;
    run_throw(2, 1'b0, 1'b0, 1'b0);
    idle_tick;

    // start pulses during PRESS and RELEASE are ignored
    start = 1'b1;
    run_throw(0, 1'b0, 1'b0, 1'b1);
    idle_tick;
    idle_tick;

    // start with enable low does not launch a throw
    enable = 1'b0;
    start  = 1'b1;
    idle_tick;
    start  = 1'b0;
    enable = 1'b1;

    // Reset mid-PRESS, then the seed gives Rock again
    start = 1'b1;
    run_throw(2, 1'b1, 1'b0, 1'b0);
    idle_tick;
    start = 1'b1;
    run_throw(0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_rock", gbb_out, 2'b01);
    idle_tick;

`ifdef MJB_FORCE_THROW_EN
    force_gbb = 2'b11;
    m_force   = 2'b11;
    start     = 1'b1;
    run_throw(0, 1'b0, 1'b0, 1'b0);
    chk("forced_paper", gbb_out, 2'b11);
    force_gbb = 2'b00;
    m_force   = 2'b00;
    idle_tick;
    start = 1'b1;
    run_throw(0, 1'b0, 1'b0, 1'b0);
    idle_tick;
`endif

    // Randomized throws, aborts, resets and idle gaps
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) idle_tick;
      kind  = int'($urandom_range(0, 9));
      start = 1'b1;
      if (kind <= 1) begin
        run_throw(int'($urandom_range(1, HOLD)), 1'b0, 1'b0, 1'b0);
      end else if (kind == 2) begin
        run_throw(int'($urandom_range(1, HOLD)), 1'b1, 1'b0, 1'b0);
      end else if (kind == 3) begin
        run_throw(0, 1'b0, 1'b0, 1'b1);
      end else begin
        run_throw(0, 1'b0, 1'b0, 1'b0);
      end
      idle_tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
